// File: rtl/route_mutator.sv
// Swap-mutation stage of the TSP GA pipeline: scans each city position once and randomly swaps it with an LFSR-picked position.
// Optional lifetime swap counter is built when ROUTE_MUTATOR_STATS_EN is defined.
module route_mutator #(
    parameter int          NUM_CITIES = 8,
    parameter int          CITY_W     = 3,
    parameter int          MUT_RATE   = 4,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         seed_load,
    input  logic [15:0]                  seed,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NUM_CITIES*CITY_W-1:0] in_route,
    input  logic                         in_elite,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NUM_CITIES*CITY_W-1:0] out_route,
    output logic [CITY_W:0]              out_swaps,
    output logic                         busy,
    output logic [15:0]                  total_mut
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    localparam logic [15:0]       LFSR_MASK = 16'hB400;
    localparam logic [15:0]       ZERO_SEED_SUB = 16'hACE1;
    localparam logic [10:0]       MUT_THR   = 11'(MUT_RATE);
    localparam logic [CITY_W-1:0] POS_LAST  = CITY_W'(NUM_CITIES - 1);
    localparam logic [CITY_W-1:0] POS_ONE   = CITY_W'(1);
    localparam logic [CITY_W:0]   SWAP_ONE  = (CITY_W + 1)'(1);

    // Galois right-shift step; feedback applied when the bit shifted out is 1
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        logic [15:0] n;
        n = {1'b0, s[15:1]};
        if (s[0]) begin
            n = n ^ LFSR_MASK;
        end else begin
            n = n;
        end
        return n;
    endfunction

    state_t                                state_r, state_nx;
    logic [15:0]                           lfsr_r, lfsr_nx;
    logic [NUM_CITIES-1:0][CITY_W-1:0]     route_r, route_nx;
    logic [CITY_W-1:0]                     pos_r, pos_nx;
    logic [CITY_W:0]                       swaps_r, swaps_nx;
    logic                                  in_ready_r, out_valid_r, busy_r;

    logic                                  hit_s;
    logic [CITY_W-1:0]                     j_s;
    logic [CITY_W-1:0]                     city_a_s, city_b_s;
    logic                                  accept_s, handshake_s;

    // Next-state and datapath update for the IDLE/SCAN/OUT sequence
    always_comb begin
        state_nx    = state_r;
        lfsr_nx     = lfsr_r;
        route_nx    = route_r;
        pos_nx      = pos_r;
        swaps_nx    = swaps_r;
        hit_s       = ({1'b0, lfsr_r[9:0]} < MUT_THR);
        j_s         = lfsr_r[15 -: CITY_W];
        city_a_s    = route_r[pos_r];
        city_b_s    = route_r[j_s];
        accept_s    = in_valid && in_ready_r;
        handshake_s = out_valid_r && out_ready;

        case (state_r)
            ST_IDLE: begin
                // A seed loaded alongside an accept is the one SCAN starts from
                if (seed_load) begin
                    if (seed == 16'h0000) begin
                        lfsr_nx = ZERO_SEED_SUB;
                    end else begin
                        lfsr_nx = seed;
                    end
                end else begin
                    lfsr_nx = lfsr_r;
                end
                if (accept_s) begin
                    route_nx = in_route;
                    pos_nx   = '0;
                    swaps_nx = '0;
                    if (in_elite) begin
                        state_nx = ST_OUT;
                    end else begin
                        state_nx = ST_SCAN;
                    end
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_SCAN: begin
                lfsr_nx = lfsr_step(lfsr_r);
                if (hit_s) begin
                    route_nx[pos_r] = city_b_s;
                    route_nx[j_s]   = city_a_s;
                    if (j_s != pos_r) begin
                        swaps_nx = swaps_r + SWAP_ONE;
                    end else begin
                        swaps_nx = swaps_r;
                    end
                end else begin
                    route_nx = route_r;
                end
                pos_nx = pos_r + POS_ONE;
                if (pos_r == POS_LAST) begin
                    state_nx = ST_OUT;
                end else begin
                    state_nx = ST_SCAN;
                end
            end
            ST_OUT: begin
                if (handshake_s) begin
                    state_nx = ST_IDLE;
                end else begin
                    state_nx = ST_OUT;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // State, datapath registers and handshake flags registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            lfsr_r      <= LFSR_SEED;
            route_r     <= '0;
            pos_r       <= '0;
            swaps_r     <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nx;
            lfsr_r      <= lfsr_nx;
            route_r     <= route_nx;
            pos_r       <= pos_nx;
            swaps_r     <= swaps_nx;
            in_ready_r  <= (state_nx == ST_IDLE);
            out_valid_r <= (state_nx == ST_OUT);
            busy_r      <= (state_nx != ST_IDLE);
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign out_route = route_r;
    assign out_swaps = swaps_r;

`ifdef ROUTE_MUTATOR_STATS_EN
    // Saturating accumulate so the lifetime count never wraps
    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [CITY_W:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + 17'(b);
        if (sum[16]) begin
            return 16'hFFFF;
        end else begin
            return sum[15:0];
        end
    endfunction

    logic [15:0] total_mut_r;

    // Lifetime swap counter, bumped on each output handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total_mut_r <= 16'h0000;
        end else if (handshake_s) begin
            total_mut_r <= sat_add(total_mut_r, swaps_r);
        end else begin
            total_mut_r <= total_mut_r;
        end
    end

    assign total_mut = total_mut_r;
`else
    assign total_mut = 16'h0000;
`endif

endmodule

// File: tb/tb_route_mutator.sv
// Bench for route_mutator: three instances (MUT_RATE 0, 1024, 64) driven in lockstep, checked against a software LFSR+swap model.
module tb_route_mutator;

    logic        clk, rst_n, seed_load, in_valid, in_elite, out_ready;
    logic [15:0] seed;
    logic [23:0] in_route;

    logic        in_ready_w [3];
    logic        out_valid_w[3];
    logic        busy_w     [3];
    logic [23:0] out_route_w[3];
    logic [3:0]  out_swaps_w[3];
    logic [15:0] total_mut_w[3];

    route_mutator #(.NUM_CITIES(8), .CITY_W(3), .MUT_RATE(0), .LFSR_SEED(16'hACE1)) u_r0 (
        .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed(seed),
        .in_valid(in_valid), .in_ready(in_ready_w[0]), .in_route(in_route), .in_elite(in_elite),
        .out_valid(out_valid_w[0]), .out_ready(out_ready), .out_route(out_route_w[0]),
        .out_swaps(out_swaps_w[0]), .busy(busy_w[0]), .total_mut(total_mut_w[0]));
    route_mutator #(.NUM_CITIES(8), .CITY_W(3), .MUT_RATE(1024), .LFSR_SEED(16'hACE1)) u_r1 (
        .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed(seed),
        .in_valid(in_valid), .in_ready(in_ready_w[1]), .in_route(in_route), .in_elite(in_elite),
        .out_valid(out_valid_w[1]), .out_ready(out_ready), .out_route(out_route_w[1]),
        .out_swaps(out_swaps_w[1]), .busy(busy_w[1]), .total_mut(total_mut_w[1]));
    route_mutator #(.NUM_CITIES(8), .CITY_W(3), .MUT_RATE(64), .LFSR_SEED(16'hACE1)) u_r2 (
        .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed(seed),
        .in_valid(in_valid), .in_ready(in_ready_w[2]), .in_route(in_route), .in_elite(in_elite),
        .out_valid(out_valid_w[2]), .out_ready(out_ready), .out_route(out_route_w[2]),
        .out_swaps(out_swaps_w[2]), .busy(busy_w[2]), .total_mut(total_mut_w[2]));

    typedef struct {
        logic [23:0] route;
        logic        elite;
        logic        sl;
        logic [15:0] sd;
        int          hold;
        logic        noise;
        int          exp_lat;
    } vec_t;

    typedef struct packed {
        logic [2:0][23:0] r;
        logic [2:0][3:0]  sw;
    } exp_t;

    exp_t        sbq[$];
    int          total = 0;
    int          bad   = 0;
    int          rates[3];
    int          swap_sum[3];
    logic [15:0] m_lfsr;
    vec_t        vecs[6];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] step(input logic [15:0] s);
        logic [15:0] n;
        n = s >> 1;
        if (s[0]) n = n ^ 16'hB400;
        return n;
    endfunction

    task automatic model(input logic [23:0] rin, input int rate, input logic [15:0] s0,
                         output logic [23:0] rout, output int sw);
        logic [2:0]  c[8];
        logic [2:0]  t;
        logic [15:0] s;
        int          j;
        for (int k = 0; k < 8; k++) c[k] = rin[k*3 +: 3];
        s  = s0;
        sw = 0;
        for (int p = 0; p < 8; p++) begin
            if (int'(s[9:0]) < rate) begin
                j    = int'(s[15:13]);
                t    = c[p];
                c[p] = c[j];
                c[j] = t;
                if (j != p) sw++;
            end
            s = step(s);
        end
        for (int k = 0; k < 8; k++) rout[k*3 +: 3] = c[k];
    endtask

    task automatic check_reset(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk({tag, "_in_ready"},  32'(in_ready_w[i]),  32'd1);
            chk({tag, "_out_valid"}, 32'(out_valid_w[i]), 32'd0);
            chk({tag, "_out_route"}, 32'(out_route_w[i]), 32'd0);
            chk({tag, "_out_swaps"}, 32'(out_swaps_w[i]), 32'd0);
            chk({tag, "_busy"},      32'(busy_w[i]),      32'd0);
            chk({tag, "_total_mut"}, 32'(total_mut_w[i]), 32'd0);
        end
    endtask

    task automatic run_route(input vec_t v);
        exp_t        e;
        logic [23:0] r;
        logic [23:0] held;
        logic [7:0]  m;
        int          sw;
        int          lat;
        @(negedge clk);
        chk("idle_ready", 32'(in_ready_w[0]), 32'd1);
        in_route  = v.route;
        in_elite  = v.elite;
        seed_load = v.sl;
        seed      = v.sd;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        if (v.sl) m_lfsr = (v.sd == 16'h0000) ? 16'hACE1 : v.sd;
        for (int i = 0; i < 3; i++) begin
            if (v.elite) begin
                r  = v.route;
                sw = 0;
            end else begin
                model(v.route, rates[i], m_lfsr, r, sw);
            end
            e.r[i]  = r;
            e.sw[i] = 4'(sw);
        end
        if (!v.elite) for (int k = 0; k < 8; k++) m_lfsr = step(m_lfsr);
        sbq.push_back(e);
        @(negedge clk);
        in_valid  = 1'b0;
        seed_load = v.noise;
        seed      = 16'h5555;
        chk("busy_after_accept", 32'(busy_w[0]), 32'd1);
        chk("ready_after_accept", 32'(in_ready_w[0]), 32'd0);
        lat = 1;
        while (out_valid_w[0] !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), 32'(v.exp_lat));
        held = out_route_w[1];
        for (int h = 0; h < v.hold; h++) begin
            chk("hold_valid", 32'(out_valid_w[1]), 32'd1);
            chk("hold_route", 32'(out_route_w[1]), 32'(held));
            chk("hold_in_ready", 32'(in_ready_w[1]), 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        seed_load = 1'b0;
        if (sbq.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = sbq.pop_front();
            for (int i = 0; i < 3; i++) begin
                chk("out_valid", 32'(out_valid_w[i]), 32'd1);
                chk("out_route", 32'(out_route_w[i]), 32'(e.r[i]));
                chk("out_swaps", 32'(out_swaps_w[i]), 32'(e.sw[i]));
                m = '0;
                for (int k = 0; k < 8; k++) m[out_route_w[i][k*3 +: 3]] = 1'b1;
                chk("permutation", 32'(m), 32'hFF);
                swap_sum[i] += int'(e.sw[i]);
            end
        end
        @(negedge clk);
        out_ready = 1'b0;
        chk("post_valid", 32'(out_valid_w[0]), 32'd0);
        chk("post_ready", 32'(in_ready_w[0]), 32'd1);
        chk("post_busy", 32'(busy_w[0]), 32'd0);
    endtask

    initial begin
        vec_t        v;
        logic [2:0]  p[8];
        logic [2:0]  t;
        int          j;
        logic [15:0] exp_tot;

        rates[0] = 0; rates[1] = 1024; rates[2] = 64;
        for (int i = 0; i < 3; i++) swap_sum[i] = 0;
        m_lfsr = 16'hACE1;

        vecs[0] = '{route: {3'd7,3'd6,3'd5,3'd4,3'd3,3'd2,3'd1,3'd0}, elite: 1'b0, sl: 1'b0, sd: 16'h0000, hold: 0, noise: 1'b0, exp_lat: 9};
        vecs[1] = '{route: {3'd0,3'd1,3'd2,3'd3,3'd4,3'd5,3'd6,3'd7}, elite: 1'b1, sl: 1'b1, sd: 16'h1234, hold: 5, noise: 1'b0, exp_lat: 1};
        vecs[2] = '{route: {3'd3,3'd0,3'd6,3'd1,3'd7,3'd2,3'd5,3'd4}, elite: 1'b0, sl: 1'b0, sd: 16'h0000, hold: 5, noise: 1'b1, exp_lat: 9};
        vecs[3] = '{route: {3'd5,3'd7,3'd1,3'd0,3'd2,3'd4,3'd6,3'd3}, elite: 1'b0, sl: 1'b1, sd: 16'h0000, hold: 2, noise: 1'b0, exp_lat: 9};
        vecs[4] = '{route: {3'd2,3'd4,3'd6,3'd0,3'd1,3'd3,3'd5,3'd7}, elite: 1'b0, sl: 1'b1, sd: 16'hFFFF, hold: 1, noise: 1'b1, exp_lat: 9};
        vecs[5] = '{route: {3'd6,3'd2,3'd0,3'd7,3'd5,3'd3,3'd1,3'd4}, elite: 1'b1, sl: 1'b0, sd: 16'h0000, hold: 0, noise: 1'b1, exp_lat: 1};

        rst_n = 1'b0; seed_load = 1'b0; seed = 16'h0000; in_valid = 1'b0;
        in_elite = 1'b0; out_ready = 1'b0; in_route = '0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst_n = 1'b1;

        for (int n = 0; n < 6; n++) run_route(vecs[n]);

        // Reset while SCAN is at pos 3: nothing emitted, LFSR back to its reset seed
        @(negedge clk);
        in_route = {3'd1,3'd3,3'd5,3'd7,3'd0,3'd2,3'd4,3'd6};
        in_elite = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_reset_busy", 32'(busy_w[1]), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset("midreset");
        rst_n = 1'b1;
        m_lfsr = 16'hACE1;
        for (int i = 0; i < 3; i++) swap_sum[i] = 0;
        run_route(vecs[0]);

        for (int n = 0; n < 1000; n++) begin
            for (int k = 0; k < 8; k++) p[k] = 3'(k);
            for (int k = 7; k > 0; k--) begin
                j    = int'($urandom_range(k, 0));
                t    = p[k];
                p[k] = p[j];
                p[j] = t;
            end
            for (int k = 0; k < 8; k++) v.route[k*3 +: 3] = p[k];
            v.elite   = ($urandom_range(7, 0) == 0);
            v.sl      = (n == 0);
            v.sd      = 16'h0000;
            v.hold    = ($urandom_range(3, 0) == 0) ? 1 : 0;
            v.noise   = 1'($urandom_range(1, 0));
            v.exp_lat = v.elite ? 1 : 9;
            run_route(v);
        end

        for (int i = 0; i < 3; i++) begin
`ifdef ROUTE_MUTATOR_STATS_EN
            exp_tot = (swap_sum[i] > 65535) ? 16'hFFFF : 16'(swap_sum[i]);
`else
            exp_tot = 16'h0000;
`endif
            chk("total_mut", 32'(total_mut_w[i]), 32'(exp_tot));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
